// File: rtl/neopixel_frame_buffer.sv
// Double-buffered pixel store and frame scheduler feeding the NeoPixel serialiser.
// Optional per-channel brightness scaling on the read port: define NEOPIXEL_FB_BRIGHTNESS_EN.
module neopixel_frame_buffer #(
  parameter int NUM_PIXELS     = 8,
  parameter int REFRESH_CYCLES = 450000,
  parameter int TIMER_W        = 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_addr,
  input  logic [23:0] i_wr_data,
  input  logic        i_commit,
  output logic        o_commit_pend,
  input  logic        i_refresh_en,
  input  logic [7:0]  i_tx_addr,
  output logic [23:0] o_tx_data,
  output logic        o_tx_start,
  output logic [15:0] o_frame_cnt
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
  ,
  input  logic [7:0]  i_brightness
`endif
);

  localparam int                 AW         = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [7:0]         PIX_LIMIT  = 8'(NUM_PIXELS);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWAP  = 2'd1,
    S_START = 2'd2
  } state_e;

  state_e             state_q;
  logic               front_q;
  logic               pend_q;
  logic               start_q;
  logic [15:0]        frame_cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic               tick_s;
  logic               wr_hit_s;
  logic [23:0]        raw_s;

  logic [23:0] bank0_q [NUM_PIXELS];
  logic [23:0] bank1_q [NUM_PIXELS];

  assign wr_hit_s = i_wr_en && (i_wr_addr < PIX_LIMIT);
  assign tick_s   = (timer_q == TIMER_LAST);
  assign timer_d  = tick_s ? {TIMER_W{1'b0}} : (timer_q + TIMER_ONE);

  // Host writes always land in the bank that is not being displayed before this edge.
  always_ff @(posedge i_clk) begin
    if (wr_hit_s) begin
      if (front_q) begin
        bank0_q[i_wr_addr[AW-1:0]] <= i_wr_data;
      end else begin
        bank1_q[i_wr_addr[AW-1:0]] <= i_wr_data;
      end
    end
  end

  // Free-running frame timer; the wrap cycle is the frame tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timer_q <= {TIMER_W{1'b0}};
    end else begin
      timer_q <= timer_d;
    end
  end

  // Frame scheduler: swap banks only at the tick boundary, then issue the start pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      front_q     <= 1'b0;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pend_q <= pend_q | i_commit;
          if (tick_s) begin
            state_q <= S_SWAP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SWAP: begin
          // A commit arriving in this cycle survives the clear and waits for the next tick.
          front_q <= front_q ^ pend_q;
          pend_q  <= i_commit;
          state_q <= S_START;
        end
        S_START: begin
          pend_q  <= pend_q | i_commit;
          start_q <= i_refresh_en;
          if (i_refresh_en) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            frame_cnt_q <= frame_cnt_q;
          end
          state_q <= S_IDLE;
        end
        default: begin
          pend_q  <= pend_q | i_commit;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Zero-latency front-bank read; out-of-range addresses read as black.
  always_comb begin
    raw_s = 24'h000000;
    if (i_tx_addr < PIX_LIMIT) begin
      if (front_q) begin
        raw_s = bank1_q[i_tx_addr[AW-1:0]];
      end else begin
        raw_s = bank0_q[i_tx_addr[AW-1:0]];
      end
    end else begin
      raw_s = 24'h000000;
    end
  end

`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] level);
    logic [16:0] prod;
    prod = {9'd0, ch} * ({9'd0, level} + 17'd1);
    return prod[15:8];
  endfunction

  assign o_tx_data = {scale_ch(raw_s[23:16], i_brightness),
                      scale_ch(raw_s[15:8],  i_brightness),
                      scale_ch(raw_s[7:0],   i_brightness)};
`else
  assign o_tx_data = raw_s;
`endif

  assign o_commit_pend = pend_q;
  assign o_tx_start    = start_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_neopixel_frame_buffer.sv
// Self-checking bench for neopixel_frame_buffer: frame-level reference model plus directed checks.
module tb_neopixel_frame_buffer;

  localparam int NP = 8;
  localparam int RC = 100;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [7:0]  i_wr_addr = 8'd0;
  logic [23:0] i_wr_data = 24'd0;
  logic        i_commit = 1'b0;
  logic        i_refresh_en = 1'b1;
  logic [7:0]  i_tx_addr = 8'd0;
  logic        o_commit_pend;
  logic [23:0] o_tx_data;
  logic        o_tx_start;
  logic [15:0] o_frame_cnt;
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
  logic [7:0]  i_brightness = 8'hFF;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model: frame events derived from the edge count since reset.
  logic [23:0] m_bank  [2][NP];
  bit          m_valid [2][NP];
  int          m_n = 0;
  bit          m_front = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_start = 1'b0;
  int          m_cnt = 0;

  neopixel_frame_buffer #(
    .NUM_PIXELS(NP), .REFRESH_CYCLES(RC), .TIMER_W(20)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_commit(i_commit), .o_commit_pend(o_commit_pend),
    .i_refresh_en(i_refresh_en), .i_tx_addr(i_tx_addr), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_frame_cnt(o_frame_cnt)
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
    , .i_brightness(i_brightness)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] shade(input logic [23:0] p);
`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
    int lv = int'(i_brightness) + 1;
    return {8'((int'(p[23:16]) * lv) / 256), 8'((int'(p[15:8]) * lv) / 256), 8'((int'(p[7:0]) * lv) / 256)};
`else
    return p;
`endif
  endfunction

  task automatic model_step();
    int wb;
    wb = m_front ? 0 : 1;
    if (i_wr_en && int'(i_wr_addr) < NP) begin
      m_bank[wb][int'(i_wr_addr)]  = i_wr_data;
      m_valid[wb][int'(i_wr_addr)] = 1'b1;
    end
    if (i_reset) begin
      m_n = 0; m_front = 1'b0; m_pend = 1'b0; m_start = 1'b0; m_cnt = 0;
    end else begin
      m_n++;
      m_start = 1'b0;
      if (m_n > 1 && m_n % RC == 1) begin
        if (m_pend) m_front = !m_front;
        m_pend = i_commit;
      end else begin
        m_pend = m_pend | i_commit;
      end
      if (m_n > 2 && m_n % RC == 2) begin
        m_start = i_refresh_en;
        if (i_refresh_en) m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      int fb;
      int a;
      fb = m_front ? 1 : 0;
      a  = int'(i_tx_addr);
      check("m_pend",  32'(o_commit_pend), 32'(m_pend));
      check("m_start", 32'(o_tx_start),    32'(m_start));
      check("m_cnt",   32'(o_frame_cnt),   32'(m_cnt));
      if (a >= NP) check("m_data_oob", 32'(o_tx_data), 32'd0);
      else if (m_valid[fb][a]) check("m_data", 32'(o_tx_data), 32'(shade(m_bank[fb][a])));
    end
  end

  task automatic wr(input int addr, input logic [23:0] data);
    @(posedge clk); #1;
    i_wr_en = 1'b1; i_wr_addr = 8'(addr); i_wr_data = data;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic commit_pulse();
    @(posedge clk); #1 i_commit = 1'b1;
    @(posedge clk); #1 i_commit = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    for (int k = 0; k < 3 * RC; k++) begin
      @(negedge clk);
      cyc++;
      if (o_tx_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL wait_start: got no pulse expected pulse within %0d cycles", 3 * RC);
    end
  endtask

  initial begin
    int cyc;
    bit found;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_cnt",   32'(o_frame_cnt),   32'd0);
    check("rst_start", 32'(o_tx_start),    32'd0);
    check("rst_pend",  32'(o_commit_pend), 32'd0);

    // 1: fill back bank, no commit, tick still pulses start.
    for (int i = 0; i < NP; i++) wr(i, 24'h0000FF);
    wait_start(cyc);
    check("t1_start", 32'(o_tx_start),    32'd1);
    check("t1_cnt",   32'(o_frame_cnt),   32'd1);
    check("t1_pend",  32'(o_commit_pend), 32'd0);
    commit_pulse();
    wait_start(cyc);
    check("t1_data0", 32'(o_tx_data),   32'h0000FF);
    check("t1_cnt2",  32'(o_frame_cnt), 32'd2);

    // 2: fill the other bank, mark pixel 3, commit and watch the swap ordering.
    for (int i = 0; i < NP; i++) wr(i, 24'(24'h100000 + i));
    wr(3, 24'hA5A5A5);
    i_tx_addr = 8'd3;
    commit_pulse();
    found = 1'b0;
    for (int k = 0; k < 3 * RC; k++) begin
      @(negedge clk);
      if (!o_commit_pend) begin
        found = 1'b1;
        break;
      end
    end
    check("t2_swapped", 32'(found),       32'd1);
    check("t2_data3",   32'(o_tx_data),   32'hA5A5A5);
    check("t2_start0",  32'(o_tx_start),  32'd0);
    @(negedge clk);
    check("t2_start1",  32'(o_tx_start),  32'd1);
    check("t2_cnt",     32'(o_frame_cnt), 32'd3);

    // 3: commit held through the swap cycle stays pending and swaps back next tick.
    @(posedge clk); #1 i_commit = 1'b1;
    wait_start(cyc);
    check("t3_pend",  32'(o_commit_pend), 32'd1);
    check("t3_data3", 32'(o_tx_data),     32'h0000FF);
    @(posedge clk); #1 i_commit = 1'b0;
    wait_start(cyc);
    check("t3b_pend",  32'(o_commit_pend), 32'd0);
    check("t3b_data3", 32'(o_tx_data),     32'hA5A5A5);
    check("t3b_cnt",   32'(o_frame_cnt),   32'd5);

    // 4: out-of-range write and reads.
    wr(8, 24'hFFFFFF);
    i_tx_addr = 8'd9;
    @(negedge clk);
    check("t4_oob9", 32'(o_tx_data), 32'd0);
    @(posedge clk); #1 i_tx_addr = 8'd0;
    @(negedge clk);
    check("t4_data0", 32'(o_tx_data), 32'h100000);

    // 5: refresh disabled: swap still occurs, no start pulses.
    @(posedge clk); #1 i_refresh_en = 1'b0;
    commit_pulse();
    repeat (3 * RC) @(negedge clk);
    check("t5_cnt",   32'(o_frame_cnt),   32'd5);
    check("t5_data0", 32'(o_tx_data),     32'h0000FF);
    check("t5_pend",  32'(o_commit_pend), 32'd0);
    @(posedge clk); #1 i_refresh_en = 1'b1;

    // 6: reset with a commit pending discards it and restarts the frame timer.
    commit_pulse();
    @(posedge clk); #1 i_reset = 1'b1;
    @(posedge clk); #1 i_reset = 1'b0;
    @(negedge clk);
    check("t6_pend",  32'(o_commit_pend), 32'd0);
    check("t6_cnt",   32'(o_frame_cnt),   32'd0);
    check("t6_data0", 32'(o_tx_data),     32'h100000);
    wait_start(cyc);
    check("t6_latency", 32'(cyc),         32'd102);
    check("t6_cnt1",    32'(o_frame_cnt), 32'd1);
    check("t6_data0b",  32'(o_tx_data),   32'h100000);

`ifdef NEOPIXEL_FB_BRIGHTNESS_EN
    wr(5, 24'hFF8000);
    commit_pulse();
    wait_start(cyc);
    i_brightness = 8'h7F;
    i_tx_addr = 8'd5;
    @(negedge clk);
    check("br_7f", 32'(o_tx_data), 32'h7F4000);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
